// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - Frame sequencer between an upstream beat source and a streaming FFT pipeline
//
// Feeds BEATS-beat frames into the FFT, limits frames inside the pipeline to
// MAX_INFLIGHT, and marks frame boundaries on the FFT output stream.
//
// Optional feature macro: FFT_FRAME_CTRL_STATS_EN (frame start / end counters).
//
// Ports:
//   clk, rstn                  clock, synchronous active-high reset
//   cfg_en                     permits new frame starts
//   s_frame_avail              upstream holds a complete frame
//   s_valid, s_last, s_ready   upstream beat handshake
//   fft_valid_in               valid into the FFT pipeline
//   fft_valid_out              valid out of the FFT pipeline
//   m_valid, m_sof, m_eof      output beat valid and frame markers
//   inflight, busy             occupancy status
//   err_gap, err_len, err_ovf  sticky error flags
//   stat_in, stat_out          frame start / frame end counters (zero without the macro)

module fft_frame_ctrl #(
  parameter int BEATS        = 32,
  parameter int MAX_INFLIGHT = 2,
  parameter int CW           = 6
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cfg_en,
  input  logic        s_frame_avail,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic        fft_valid_in,
  input  logic        fft_valid_out,
  output logic        m_valid,
  output logic        m_sof,
  output logic        m_eof,
  output logic [1:0]  inflight,
  output logic        busy,
  output logic        err_gap,
  output logic        err_len,
  output logic        err_ovf,
  output logic [15:0] stat_in,
  output logic [15:0] stat_out
);

  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [2:0]    MAX_INF   = 3'(MAX_INFLIGHT);

  typedef enum logic {
    IDLE = 1'b0,
    FEED = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] in_cnt, in_cnt_nxt;
  logic [CW-1:0] out_cnt;
  logic [1:0]    inflight_q, inflight_nxt;

  logic accept;
  logic first_beat;
  logic last_beat;
  logic out_beat;
  logic eof_beat;
  logic credit_ok;
  logic start_ok;

  // Outputs are forced low while reset is held so nothing leaks out of a
  // state that is about to be discarded.
  assign s_ready      = (state == FEED) & ~rstn;
  assign accept       = s_valid & s_ready;
  assign fft_valid_in = accept;

  assign first_beat = accept & (in_cnt == '0);
  assign last_beat  = accept & (in_cnt == LAST_BEAT);

  // An output beat with nothing in flight is an overflow: it is swallowed
  // and does not advance the output frame position.
  assign out_beat = fft_valid_out & (inflight_q != 2'd0) & ~rstn;
  assign eof_beat = out_beat & (out_cnt == LAST_BEAT);

  assign m_valid = out_beat;
  assign m_sof   = out_beat & (out_cnt == '0);
  assign m_eof   = eof_beat;

  always_comb begin
    inflight_nxt = inflight_q;
    case ({first_beat, eof_beat})
      2'b10:   inflight_nxt = inflight_q + 2'd1;
      2'b01:   inflight_nxt = inflight_q - 2'd1;
      default: inflight_nxt = inflight_q;
    endcase
  end

  // Credit is judged on the occupancy after this cycle, so a frame end on
  // the output side frees a slot in time for the very next cycle.
  assign credit_ok = ({1'b0, inflight_nxt} < MAX_INF);
  assign start_ok  = cfg_en & s_frame_avail & credit_ok;

  always_comb begin
    state_nxt  = state;
    in_cnt_nxt = in_cnt;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt  = FEED;
          in_cnt_nxt = '0;
        end
      end
      FEED: begin
        if (accept) begin
          if (last_beat) begin
            in_cnt_nxt = '0;
            if (!start_ok) begin
              state_nxt = IDLE;
            end
          end else begin
            in_cnt_nxt = in_cnt + CW'(1);
          end
        end
      end
      default: begin
        state_nxt  = IDLE;
        in_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state      <= IDLE;
      in_cnt     <= '0;
      out_cnt    <= '0;
      inflight_q <= 2'd0;
      err_gap    <= 1'b0;
      err_len    <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_cnt     <= in_cnt_nxt;
      inflight_q <= inflight_nxt;
      if (out_beat) begin
        out_cnt <= eof_beat ? '0 : out_cnt + CW'(1);
      end
      if ((state == FEED) && !s_valid) begin
        err_gap <= 1'b1;
      end
      // s_last must be set exactly on the final beat of the frame.
      if (accept && (s_last != (in_cnt == LAST_BEAT))) begin
        err_len <= 1'b1;
      end
      if (fft_valid_out && (inflight_q == 2'd0)) begin
        err_ovf <= 1'b1;
      end
    end
  end

  assign inflight = inflight_q;
  assign busy     = ((state != IDLE) | (inflight_q != 2'd0)) & ~rstn;

`ifdef FFT_FRAME_CTRL_STATS_EN
  logic        frame_start;
  logic [15:0] stat_in_q;
  logic [15:0] stat_out_q;

  // A start is either leaving IDLE or chaining into the next frame.
  assign frame_start = start_ok & ((state == IDLE) | last_beat);

  always_ff @(posedge clk) begin
    if (rstn) begin
      stat_in_q  <= 16'd0;
      stat_out_q <= 16'd0;
    end else begin
      if (frame_start) begin
        stat_in_q <= stat_in_q + 16'd1;
      end
      if (eof_beat) begin
        stat_out_q <= stat_out_q + 16'd1;
      end
    end
  end

  assign stat_in  = stat_in_q;
  assign stat_out = stat_out_q;
`else
  assign stat_in  = 16'd0;
  assign stat_out = 16'd0;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb/tb_fft_frame_ctrl.sv - Self-checking bench for fft_frame_ctrl

module tb_fft_frame_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_en;
  logic        s_frame_avail;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic        fft_valid_in;
  logic        fft_valid_out;
  logic        m_valid;
  logic        m_sof;
  logic        m_eof;
  logic [1:0]  inflight;
  logic        busy;
  logic        err_gap;
  logic        err_len;
  logic        err_ovf;
  logic [15:0] stat_in;
  logic [15:0] stat_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic v;
    logic sof;
    logic eof;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  fft_frame_ctrl #(.BEATS(32), .MAX_INFLIGHT(2), .CW(6)) dut (
    .clk(clk), .rstn(rstn), .cfg_en(cfg_en), .s_frame_avail(s_frame_avail),
    .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .fft_valid_in(fft_valid_in), .fft_valid_out(fft_valid_out),
    .m_valid(m_valid), .m_sof(m_sof), .m_eof(m_eof),
    .inflight(inflight), .busy(busy),
    .err_gap(err_gap), .err_len(err_len), .err_ovf(err_ovf),
    .stat_in(stat_in), .stat_out(stat_out)
  );

  always #5 clk = ~clk;

  // Output scoreboard: every driven fft_valid_out beat has an expected entry.
  always @(negedge clk) begin
    if (fft_valid_out === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: output beat v/sof/eof=%b%b%b with no expected entry", m_valid, m_sof, m_eof);
      end else begin
        mon_e = exp_q.pop_front();
        if ({m_valid, m_sof, m_eof} !== {mon_e.v, mon_e.sof, mon_e.eof}) begin
          errors++;
          $display("FAIL sb_beat: got v/sof/eof=%b%b%b expected %b%b%b",
                   m_valid, m_sof, m_eof, mon_e.v, mon_e.sof, mon_e.eof);
        end
      end
    end
  end

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    cfg_en = 1'b0; s_frame_avail = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    fft_valid_out = 1'b0;
    step_edge();
    step_edge();
    rstn = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    cfg_en = 1'b1; s_frame_avail = 1'b1; s_valid = 1'b1; s_last = 1'b0;
    fft_valid_out = 1'b0;
    step_edge();
    fft_valid_out = 1'b1;
    exp_q.push_back('{v: 1'b0, sof: 1'b0, eof: 1'b0});
    @(negedge clk);
    checks++;
    if ({s_ready, fft_valid_in, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: ready/vin/busy=%b%b%b expected 000", s_ready, fft_valid_in, busy);
    end
    checks++;
    if (inflight !== 2'd0) begin
      errors++; $display("FAIL reset_inflight: got %0d expected 0", inflight);
    end
    step_edge();
    fft_valid_out = 1'b0;
    @(negedge clk);
    checks++;
    if ({err_gap, err_len, err_ovf} !== 3'b000) begin
      errors++; $display("FAIL reset_err: gap/len/ovf=%b%b%b expected 000", err_gap, err_len, err_ovf);
    end
    checks++;
    if ({stat_in, stat_out} !== 32'd0) begin
      errors++; $display("FAIL reset_stat: in=%0d out=%0d expected 0", stat_in, stat_out);
    end
    step_edge();
  endtask

  task automatic test_back_to_back();
    int nb, run, best;
    do_reset();
    cfg_en = 1'b1; s_frame_avail = 1'b1; s_valid = 1'b1;
    nb = 0; run = 0; best = 0;
    for (int c = 0; c < 100 && nb < 64; c++) begin
      s_last = ((nb % 32) == 31);
      @(negedge clk);
      if (fft_valid_in === 1'b1) begin
        nb++; run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
      step_edge();
    end
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    checks++;
    if (nb != 64) begin
      errors++; $display("FAIL b2b_beats: accepted %0d expected 64", nb);
    end
    checks++;
    if (best != 64) begin
      errors++; $display("FAIL b2b_contiguous: longest run %0d expected 64", best);
    end
    checks++;
    if (inflight !== 2'd2) begin
      errors++; $display("FAIL b2b_inflight: got %0d expected 2", inflight);
    end
    checks++;
    if ({s_ready, busy, err_gap, err_len} !== 4'b0100) begin
      errors++; $display("FAIL b2b_status: ready/busy/gap/len=%b%b%b%b expected 0100", s_ready, busy, err_gap, err_len);
    end
    step_edge();
  endtask

  // Continues from the back-to-back state: two frames in flight, avail high.
  task automatic test_credit();
    int bad_ready;
    s_valid = 1'b1; s_frame_avail = 1'b1; cfg_en = 1'b1; s_last = 1'b0;
    bad_ready = 0;
    for (int k = 0; k < 32; k++) begin
      fft_valid_out = 1'b1;
      exp_q.push_back('{v: 1'b1, sof: (k == 0), eof: (k == 31)});
      @(negedge clk);
      if (s_ready !== 1'b0) bad_ready++;
      step_edge();
    end
    fft_valid_out = 1'b0;
    @(negedge clk);
    checks++;
    if (bad_ready != 0) begin
      errors++; $display("FAIL credit_hold: s_ready high on %0d cycles expected 0", bad_ready);
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL credit_resume: s_ready=%b expected 1 after m_eof", s_ready);
    end
    checks++;
    if (inflight !== 2'd1) begin
      errors++; $display("FAIL credit_dec: inflight=%0d expected 1", inflight);
    end
    step_edge();
    s_frame_avail = 1'b0;
    @(negedge clk);
    checks++;
    if (inflight !== 2'd2) begin
      errors++; $display("FAIL credit_inc: inflight=%0d expected 2", inflight);
    end
    step_edge();
  endtask

  task automatic test_gap();
    int nb, rdy;
    bit gap_done, early;
    do_reset();
    cfg_en = 1'b1; s_frame_avail = 1'b1;
    nb = 0; rdy = 0; gap_done = 0; early = 0;
    for (int c = 0; c < 45; c++) begin
      s_frame_avail = (rdy == 0);
      s_valid = !((nb == 10) && !gap_done);
      s_last = (nb == 31);
      @(negedge clk);
      if (!gap_done && err_gap === 1'b1) early = 1;
      if (s_ready === 1'b1) rdy++;
      if (s_ready === 1'b1 && !s_valid) gap_done = 1;
      if (fft_valid_in === 1'b1) nb++;
      step_edge();
    end
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy != 33) begin
      errors++; $display("FAIL gap_ready_cycles: got %0d expected 33", rdy);
    end
    checks++;
    if (nb != 32) begin
      errors++; $display("FAIL gap_beats: got %0d expected 32", nb);
    end
    checks++;
    if ({early, err_gap, err_len} !== 3'b010) begin
      errors++; $display("FAIL gap_flags: early/gap/len=%b%b%b expected 010", early, err_gap, err_len);
    end
    checks++;
    if (inflight !== 2'd1) begin
      errors++; $display("FAIL gap_inflight: got %0d expected 1", inflight);
    end
    step_edge();
  endtask

  task automatic test_len();
    int nb, rdy;
    logic len_before;
    do_reset();
    cfg_en = 1'b1; s_frame_avail = 1'b1; s_valid = 1'b1;
    nb = 0; rdy = 0; len_before = 1'bx;
    for (int c = 0; c < 45; c++) begin
      s_frame_avail = (rdy == 0);
      s_last = (nb == 20) || (nb == 31);
      @(negedge clk);
      if (nb == 20) len_before = err_len;
      if (s_ready === 1'b1) rdy++;
      if (fft_valid_in === 1'b1) nb++;
      step_edge();
    end
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    checks++;
    if (len_before !== 1'b0) begin
      errors++; $display("FAIL len_early: err_len=%b before beat 20 expected 0", len_before);
    end
    checks++;
    if ({err_len, err_gap} !== 2'b10) begin
      errors++; $display("FAIL len_flags: len/gap=%b%b expected 10", err_len, err_gap);
    end
    checks++;
    if (nb != 32 || rdy != 32) begin
      errors++; $display("FAIL len_complete: beats=%0d ready_cycles=%0d expected 32/32", nb, rdy);
    end
    step_edge();
  endtask

  task automatic test_overlap();
    int nb, out_k, infl_at;
    do_reset();
    cfg_en = 1'b1; s_frame_avail = 1'b1; s_valid = 1'b1;
    nb = 0; out_k = 0; infl_at = -1;
    for (int c = 0; c < 100 && nb < 64; c++) begin
      s_last = ((nb % 32) == 31);
      if (nb >= 32) s_frame_avail = 1'b0;
      if (nb >= 1 && out_k < 32) begin
        fft_valid_out = 1'b1;
        exp_q.push_back('{v: 1'b1, sof: (out_k == 0), eof: (out_k == 31)});
        out_k++;
      end else begin
        fft_valid_out = 1'b0;
      end
      @(negedge clk);
      if (nb == 33) infl_at = int'(inflight);
      if (fft_valid_in === 1'b1) nb++;
      step_edge();
    end
    fft_valid_out = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    checks++;
    if (infl_at != 1) begin
      errors++; $display("FAIL overlap_inc_dec: inflight=%0d expected 1", infl_at);
    end
    checks++;
    if (nb != 64 || inflight !== 2'd1 || s_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL overlap_end: beats=%0d inflight=%0d ready=%b busy=%b expected 64/1/0/1", nb, inflight, s_ready, busy);
    end
    step_edge();
    for (int k = 0; k < 32; k++) begin
      fft_valid_out = 1'b1;
      exp_q.push_back('{v: 1'b1, sof: (k == 0), eof: (k == 31)});
      @(negedge clk);
      step_edge();
    end
    fft_valid_out = 1'b0;
    @(negedge clk);
    checks++;
    if (inflight !== 2'd0 || busy !== 1'b0 || err_ovf !== 1'b0) begin
      errors++; $display("FAIL drain: inflight=%0d busy=%b ovf=%b expected 0/0/0", inflight, busy, err_ovf);
    end
`ifdef FFT_FRAME_CTRL_STATS_EN
    checks++;
    if (stat_in !== 16'd2 || stat_out !== 16'd2) begin
      errors++; $display("FAIL stats: in=%0d out=%0d expected 2/2", stat_in, stat_out);
    end
`else
    checks++;
    if (stat_in !== 16'd0 || stat_out !== 16'd0) begin
      errors++; $display("FAIL stats_off: in=%0d out=%0d expected 0/0", stat_in, stat_out);
    end
`endif
    step_edge();
  endtask

  task automatic test_reset_mid();
    do_reset();
    cfg_en = 1'b1; s_frame_avail = 1'b1; s_valid = 1'b1; s_last = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      step_edge();
    end
    s_frame_avail = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_ready, fft_valid_in, busy} !== 3'b000) begin
      errors++; $display("FAIL midrst_outputs: ready/vin/busy=%b%b%b expected 000", s_ready, fft_valid_in, busy);
    end
    step_edge();
    rstn = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (err_ovf !== 1'b0 || inflight !== 2'd0) begin
      errors++; $display("FAIL midrst_clear: ovf=%b inflight=%0d expected 0/0", err_ovf, inflight);
    end
    step_edge();
    for (int k = 0; k < 5; k++) begin
      fft_valid_out = 1'b1;
      exp_q.push_back('{v: 1'b0, sof: 1'b0, eof: 1'b0});
      @(negedge clk);
      step_edge();
    end
    fft_valid_out = 1'b0;
    @(negedge clk);
    checks++;
    if (err_ovf !== 1'b1 || inflight !== 2'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL ovf: ovf=%b inflight=%0d busy=%b expected 1/0/0", err_ovf, inflight, busy);
    end
    checks++;
    if (stat_in !== 16'd0 || stat_out !== 16'd0) begin
      errors++; $display("FAIL midrst_stats: in=%0d out=%0d expected 0/0", stat_in, stat_out);
    end
    step_edge();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn = 1'b1;
    cfg_en = 1'b0; s_frame_avail = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    fft_valid_out = 1'b0;
    #1;
    test_reset();
    test_back_to_back();
    test_credit();
    test_gap();
    test_len();
    test_overlap();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: %0d expected beats never produced, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameters: BEATS, default 32, input beats per FFT frame (16 samples per beat); MAX_INFLIGHT, default 2, frames allowed inside the FFT pipeline at once; CW, default 6, beat-counter width.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rstn  in  1  synchronous, active-high reset (1 = reset), sampled on clk.
- cfg_en  in  1  permits new frame starts.
- s_frame_avail  in  1  upstream holds one complete frame.
- s_valid  in  1  upstream beat valid.
- s_last  in  1  upstream marks last beat of frame.
- s_ready  out  1  controller accepts a beat.
- fft_valid_in  out  1  drives the FFT pipeline valid_in.
- fft_valid_out  in  1  FFT pipeline output-beat valid.
- m_valid  out  1  output beat valid.
- m_sof  out  1  first output beat of frame.
- m_eof  out  1  last output beat of frame.
- inflight  out  2  frames currently in the FFT.
- busy  out  1  high when state is not IDLE or inflight != 0.
- err_gap, err_len, err_ovf  out  1 each  sticky error flags.
- stat_in, stat_out  out  16 each  frame counters (see REQ-019).

Function
REQ-003 SHALL implement two states, IDLE and FEED.
REQ-004 SHALL start a frame when cfg_en & s_frame_avail & (inflight < MAX_INFLIGHT). From IDLE, FEED is entered on the next cycle.
REQ-005 SHALL hold s_ready = 1 throughout FEED and s_ready = 0 in IDLE.
REQ-006 SHALL set fft_valid_in = s_valid & s_ready (combinational). The in-counter increments only on accepted beats.
REQ-007 SHALL set err_gap when s_valid = 0 in FEED (mid-frame underrun); the frame continues until BEATS beats are accepted.
REQ-008 SHALL set err_len when s_last = 1 on an accepted beat other than beat BEATS-1, or when s_last = 0 on beat BEATS-1.
REQ-009 SHALL, on acceptance of beat BEATS-1:
- stay in FEED with the in-counter cleared (zero-bubble back-to-back) if the start condition holds, with the credit check using the inflight value after this frame;
- otherwise return to IDLE.
REQ-010 SHALL increment inflight on the first accepted beat of each frame.
REQ-011 SHALL drive m_valid = fft_valid_out combinationally. An out-counter counts fft_valid_out beats 0..BEATS-1 and wraps to 0.
REQ-012 SHALL set m_sof when out-counter = 0 and m_eof when out-counter = BEATS-1, each qualified by fft_valid_out.
REQ-013 SHALL decrement inflight on each m_eof beat. A simultaneous increment and decrement SHALL leave inflight unchanged.
REQ-014 SHALL, when fft_valid_out = 1 while inflight = 0: set err_ovf, hold the out-counter, and drive m_valid = 0.
REQ-015 SHALL keep each error flag set until reset; errors do not alter sequencing.
REQ-016 SHALL let cfg_en deassertion block only new starts; a frame already in FEED completes.

Reset
REQ-017 SHALL, while rstn = 1 at a clock edge: go to IDLE; clear both counters, inflight, all error flags, and stat counters. s_ready, fft_valid_in, m_valid, m_sof, m_eof and busy SHALL read 0.
REQ-018 SHALL abandon any partial input or output frame on reset mid-frame. Later fft_valid_out beats with inflight = 0 SHALL follow REQ-014.

Configuration
REQ-019 SHALL support macro FFT_FRAME_CTRL_STATS_EN:
- when defined, stat_in counts frame starts and stat_out counts m_eof beats, both 16-bit wrapping;
- when undefined, stat_in and stat_out are tied to 0 and no counter registers exist.

Verification
REQ-020 Bench SHALL cover:
- Reset, then avail held high with cfg_en = 1 and a 64-beat contiguous stream -> two back-to-back frames; fft_valid_in high for 64 consecutive cycles; inflight = 2.
- With inflight = 2 and avail = 1 -> s_ready stays 0 until the first m_eof, then FEED on the next cycle.
- s_valid low for 1 cycle at beat 10 -> err_gap = 1; s_ready stays high for exactly 33 cycles.
- s_last asserted on beat 20 -> err_len = 1; frame still completes at beat 31.
- 32 fft_valid_out beats -> m_sof at beat 0, m_eof at beat 31, inflight decrements; beat 0 of frame 2 coincides with an input start -> inflight unchanged.
- rstn pulsed mid-FEED, then 5 fft_valid_out beats -> err_ovf = 1, m_valid = 0; with STATS_EN, stat_in = stat_out = 0 after reset.
